alu32_sched: RTL

//  Round-robin scheduler sharing one registered 32-bit ALU (alu32) among NREQ requesters.

---
 rtl/alu32_pkg.sv | 24 ++
 rtl/alu32_sched_rr_arbiter.sv | 34 +++
 rtl/alu32_sched.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/alu32_pkg.sv
// Shared types for the alu32 scheduler: ALU op codes, scheduler FSM states, datapath width.
package alu32_pkg;

    localparam int ALU_W = 32;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_NOT  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_ADD  = 3'b110,
        OP_SUB  = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } sched_state_t;

endpackage

// File: rtl/alu32_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_oh_o,
    output logic [IDW-1:0]  grant_idx_o,
    output logic            any_o
);

    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        // Upper segment [ptr..NREQ-1] first, then the wrapped segment [0..ptr-1].
        for (int i = 0; i < NREQ; i++) begin
            if (!any_o && req_i[i] && (i >= int'(ptr_i))) begin
                any_o         = 1'b1;
                grant_oh_o[i] = 1'b1;
                grant_idx_o   = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!any_o && req_i[i] && (i < int'(ptr_i))) begin
                any_o         = 1'b1;
                grant_oh_o[i] = 1'b1;
                grant_idx_o   = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/alu32_sched.sv
// Round-robin scheduler sharing one registered 32-bit ALU among NREQ requesters, one op in flight.
// Optional per-requester accept counters on stat_cnt when ALU_SCHED_STATS_EN is defined.
module alu32_sched
    import alu32_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
`ifdef ALU_SCHED_STATS_EN
    , parameter int CNTW = 16
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [3*NREQ-1:0]       req_op,
    input  logic [ALU_W*NREQ-1:0]   req_a,
    input  logic [ALU_W*NREQ-1:0]   req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [ALU_W-1:0]        rsp_data,
    output logic [2:0]              alu_op,
    output logic [ALU_W-1:0]        alu_a,
    output logic [ALU_W-1:0]        alu_b,
    input  logic [ALU_W-1:0]        alu_result,
`ifdef ALU_SCHED_STATS_EN
    output logic [CNTW*NREQ-1:0]    stat_cnt,
`endif
    output logic                    busy
);

    sched_state_t     state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    alu_op_t          alu_op_q, alu_op_d;
    logic [ALU_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [ALU_W-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;

    logic [NREQ-1:0]  grant_oh;
    logic [IDW-1:0]   grant_idx;
    logic             grant_any;
    logic             accept;
    logic [2:0]       sel_op;
    logic [ALU_W-1:0] sel_a, sel_b;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_i       (req_valid),
        .ptr_i       (rr_ptr_q),
        .grant_oh_o  (grant_oh),
        .grant_idx_o (grant_idx),
        .any_o       (grant_any)
    );

    assign accept = (state_q == IDLE) && grant_any;

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_oh[i]) begin
                sel_op = req_op[3*i +: 3];
                sel_a  = req_a[ALU_W*i +: ALU_W];
                sel_b  = req_b[ALU_W*i +: ALU_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        req_ready   = '0;
        case (state_q)
            IDLE: begin
                req_ready = grant_oh;
                if (accept) begin
                    alu_op_d = alu_op_t'(sel_op);
                    alu_a_d  = sel_a;
                    alu_b_d  = sel_b;
                    rsp_id_d = grant_idx;
                    rr_ptr_d = (int'(grant_idx) == NREQ - 1) ? '0 : IDW'(int'(grant_idx) + 1);
                    state_d  = EXEC;
                end
            end
            // ALU registers its result at the end of EXEC; NOP afterwards keeps it held.
            EXEC: begin
                alu_op_d = OP_NOP;
                state_d  = CAPT;
            end
            CAPT: begin
                rsp_data_d  = alu_result;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            alu_op_q    <= OP_NOP;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != IDLE);

`ifdef ALU_SCHED_STATS_EN
    for (genvar i = 0; i < NREQ; i++) begin : g_stat
        logic [CNTW-1:0] cnt_q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
            end else if (accept && grant_oh[i] && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNTW'(1);
            end
        end
        assign stat_cnt[CNTW*i +: CNTW] = cnt_q;
    end
`endif

endmodule
